// File: rtl/pa_isa_pkg.sv
// pa_isa_pkg: instruction/bundle widths, field positions and the field split shared by fetch, unpacker and decode.
package pa_isa_pkg;
    localparam int INSTR_W    = 30;
    localparam int BUNDLE_W   = 60;
    localparam int FORMAT_BIT = 29;
    localparam int BRANCH_BIT = 28;
    localparam int OPCODE_HI  = 27;
    localparam int OPCODE_LO  = 21;
    localparam int PRIM_HI    = 20;
    localparam int PRIM_LO    = 16;
    localparam int SEC_HI     = 15;
    localparam int SEC_LO     = 11;
    localparam int IMM_HI     = 15;
    localparam int IMM_LO     = 0;
    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic        fmt;
        logic        branch;
        logic [6:0]  opcode;
        logic [4:0]  prim;
        logic [4:0]  sec;
        logic [15:0] imm;
    } instr_fields_t;

    // sec and imm share bits, so the field not selected by the format bit reads zero
    function automatic instr_fields_t split_instr(input logic [INSTR_W-1:0] i);
        instr_fields_t f;
        f.fmt    = i[FORMAT_BIT];
        f.branch = i[BRANCH_BIT];
        f.opcode = i[OPCODE_HI:OPCODE_LO];
        f.prim   = i[PRIM_HI:PRIM_LO];
        f.sec    = i[FORMAT_BIT] ? 5'd0 : i[SEC_HI:SEC_LO];
        f.imm    = i[FORMAT_BIT] ? i[IMM_HI:IMM_LO] : 16'd0;
        return f;
    endfunction
endpackage

// File: rtl/bundle_fifo.sv
// bundle_fifo: DEPTH-entry circular bundle buffer; a push while full is taken only together with a pop.
module bundle_fifo
    import pa_isa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [BUNDLE_W-1:0]     i_data,
    output logic [BUNDLE_W-1:0]     o_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [BUNDLE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wr;
    logic [AW-1:0]       r_rd;
    logic [AW:0]         r_cnt;
    logic                w_pop;
    logic                w_push;

    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_data  = r_mem[r_rd];
    assign o_count = r_cnt;

    always_ff @(posedge i_clk)
        if (w_push && !i_flush)
            r_mem[r_wr] <= i_data;

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= r_wr + AW'(w_push);
            r_rd  <= r_rd + AW'(w_pop);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/bundle_unpacker.sv
// bundle_unpacker: fetch-to-decode bridge issuing one pre-split instruction per cycle from buffered bundles.
// BUNDLE_NOP_SKIP_EN: when defined, all-zero slots are never issued.
module bundle_unpacker
    import pa_isa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    flush_i,
    input  logic [BUNDLE_W-1:0]     bundle_i,
    input  logic                    bundle_valid_i,
    input  logic                    ready_i,
    output logic                    instr_valid_o,
    output logic [INSTR_W-1:0]      instr_o,
    output logic                    format_o,
    output logic                    branch_o,
    output logic [6:0]              opcode_o,
    output logic [4:0]              prim_reg_o,
    output logic [4:0]              sec_reg_o,
    output logic [15:0]             imm_o,
    output logic                    slot_o,
    output logic                    stall_o,
    output logic                    overflow_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [BUNDLE_W-1:0] w_head;
    logic [INSTR_W-1:0]  w_s0;
    logic [INSTR_W-1:0]  w_s1;
    logic [INSTR_W-1:0]  w_instr;
    logic                w_full;
    logic                w_empty;
    logic                w_load;
    logic                w_pop;
    logic                w_issue;
    logic                w_slot;
    logic                r_sp;
    logic                r_valid;
    logic                r_slot;
    logic                r_ovf;
    logic [INSTR_W-1:0]  r_instr;
    instr_fields_t       r_f;

    bundle_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (clock_i),
        .i_rst_n (reset_i),
        .i_flush (flush_i),
        .i_push  (bundle_valid_i),
        .i_pop   (w_pop),
        .i_data  (bundle_i),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count_o)
    );

    assign w_s0   = w_head[BUNDLE_W-1:INSTR_W];
    assign w_s1   = w_head[INSTR_W-1:0];
    assign w_load = !r_valid || ready_i;

`ifdef BUNDLE_NOP_SKIP_EN
    // a zero slot 0 is skipped straight to slot 1; a bundle whose remaining slot is zero is popped early
    assign w_slot  = r_sp || w_s0 == NOP_INSTR;
    assign w_instr = w_slot ? w_s1 : w_s0;
    assign w_issue = !w_empty && w_instr != NOP_INSTR;
    assign w_pop   = w_load && !w_empty && (w_slot || w_s1 == NOP_INSTR);
`else
    assign w_slot  = r_sp;
    assign w_instr = r_sp ? w_s1 : w_s0;
    assign w_issue = !w_empty;
    assign w_pop   = w_load && !w_empty && r_sp;
`endif

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_sp    <= 1'b0;
            r_valid <= 1'b0;
            r_slot  <= 1'b0;
            r_ovf   <= 1'b0;
            r_instr <= NOP_INSTR;
            r_f     <= '0;
        end else if (flush_i) begin
            r_sp    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_ovf <= r_ovf || (bundle_valid_i && w_full && !w_pop);
            if (w_load) begin
                r_valid <= w_issue;
                if (!w_empty)
                    r_sp <= !w_pop;
                if (w_issue) begin
                    r_instr <= w_instr;
                    r_f     <= split_instr(w_instr);
                    r_slot  <= w_slot;
                end
            end
        end
    end

    assign instr_valid_o = r_valid;
    assign instr_o       = r_instr;
    assign format_o      = r_f.fmt;
    assign branch_o      = r_f.branch;
    assign opcode_o      = r_f.opcode;
    assign prim_reg_o    = r_f.prim;
    assign sec_reg_o     = r_f.sec;
    assign imm_o         = r_f.imm;
    assign slot_o        = r_slot;
    assign overflow_o    = r_ovf;
    // one free entry is kept for the bundle already in flight from fetch
    assign stall_o       = count_o >= CW'(DEPTH - 1);
endmodule

// File: tb/tb_bundle_unpacker.sv
// tb_bundle_unpacker: directed vector table, hand-written corner sequences and a randomized run against a slot-queue model.
module tb_bundle_unpacker;
    localparam int DEPTH = 4;
    localparam logic [29:0] IA = {1'b1, 1'b0, 7'b0001010, 5'd1, 16'd5};
    localparam logic [29:0] IB = {1'b1, 1'b0, 7'd0, 5'd2, 16'd10};
    localparam logic [29:0] IC = {1'b0, 1'b1, 7'b0000110, 5'd3, 5'd2, 11'd0};
    localparam logic [29:0] ID = 30'h0ABCDE;
    localparam logic [29:0] Z  = 30'h0;

    typedef struct {
        logic        bv;
        logic [59:0] b;
        logic        rdy;
        logic        fl;
        logic        ev;
        logic [29:0] ei;
        logic        es;
        int          ec;
        logic        eo;
    } vec_t;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        bundle_valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [59:0] bundle_i = '0;
    logic        instr_valid_o;
    logic [29:0] instr_o;
    logic        format_o;
    logic        branch_o;
    logic [6:0]  opcode_o;
    logic [4:0]  prim_reg_o;
    logic [4:0]  sec_reg_o;
    logic [15:0] imm_o;
    logic        slot_o;
    logic        stall_o;
    logic        overflow_o;
    logic [2:0]  count_o;
    int          n_tests = 0;
    int          n_fail = 0;
    vec_t        tbl[12];

    logic [30:0] q[$];
    logic        m_valid;
    logic [29:0] m_instr;
    logic        m_slot;
    logic        m_ovf;

    always #5 clock_i = ~clock_i;

    bundle_unpacker #(.DEPTH(DEPTH)) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .flush_i        (flush_i),
        .bundle_i       (bundle_i),
        .bundle_valid_i (bundle_valid_i),
        .ready_i        (ready_i),
        .instr_valid_o  (instr_valid_o),
        .instr_o        (instr_o),
        .format_o       (format_o),
        .branch_o       (branch_o),
        .opcode_o       (opcode_o),
        .prim_reg_o     (prim_reg_o),
        .sec_reg_o      (sec_reg_o),
        .imm_o          (imm_o),
        .slot_o         (slot_o),
        .stall_o        (stall_o),
        .overflow_o     (overflow_o),
        .count_o        (count_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_fields(input string t, input logic [29:0] i);
        chk({t, ".format"}, format_o, i[29]);
        chk({t, ".branch"}, branch_o, i[28]);
        chk({t, ".opcode"}, opcode_o, i[27:21]);
        chk({t, ".prim"}, prim_reg_o, i[20:16]);
        chk({t, ".sec"}, sec_reg_o, i[29] ? 5'd0 : i[15:11]);
        chk({t, ".imm"}, imm_o, i[29] ? i[15:0] : 16'd0);
    endtask

    task automatic chk_state(input string t, input logic v, input logic [29:0] i, input logic s, input int c, input logic ov);
        chk({t, ".valid"}, instr_valid_o, v);
        chk({t, ".count"}, count_o, c);
        chk({t, ".stall"}, stall_o, c >= DEPTH - 1);
        chk({t, ".overflow"}, overflow_o, ov);
        if (v) begin
            chk({t, ".instr"}, instr_o, i);
            chk({t, ".slot"}, slot_o, s);
            chk_fields(t, i);
        end
    endtask

    task automatic chk_all_zero(input string t);
        chk({t, ".valid"}, instr_valid_o, 0);
        chk({t, ".instr"}, instr_o, 0);
        chk({t, ".fields"}, {format_o, branch_o, opcode_o, prim_reg_o, sec_reg_o, imm_o}, 0);
        chk({t, ".slot"}, slot_o, 0);
        chk({t, ".stall"}, stall_o, 0);
        chk({t, ".overflow"}, overflow_o, 0);
        chk({t, ".count"}, count_o, 0);
    endtask

    task automatic cycle(input logic bv, input logic [59:0] b, input logic rdy, input logic fl);
        @(negedge clock_i);
        bundle_valid_i = bv;
        bundle_i = b;
        ready_i = rdy;
        flush_i = fl;
        @(posedge clock_i);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock_i);
        reset_i = 1'b0;
        bundle_valid_i = 1'b0;
        flush_i = 1'b0;
        #1;
        reset_i = 1'b1;
    endtask

    // Reference: FIFO seen as a queue of pending slots {slot, instr}; a bundle leaves once its slot 1 is issued.
    task automatic model_step(input logic bv, input logic [59:0] b, input logic rdy, input logic fl);
        logic [30:0] e;
        logic        popped;
        int          cnt;
        popped = 1'b0;
        if (fl) begin
            q.delete();
            m_valid = 1'b0;
        end else begin
            cnt = (q.size() + 1) / 2;
            if (!m_valid || rdy) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    m_valid = 1'b1;
                    m_instr = e[29:0];
                    m_slot = e[30];
                    popped = e[30];
                end else
                    m_valid = 1'b0;
            end
            if (bv) begin
                if (cnt < DEPTH || popped) begin
                    q.push_back({1'b0, b[59:30]});
                    q.push_back({1'b1, b[29:0]});
                end else
                    m_ovf = 1'b1;
            end
        end
    endtask

    initial begin
        logic        bv;
        logic        rdy;
        logic        fl;
        logic [29:0] s0;
        logic [29:0] s1;

        tbl[0]  = '{1'b1, {IA, IB}, 1'b1, 1'b0, 1'b0, Z, 1'b0, 1, 1'b0};
        tbl[1]  = '{1'b0, 60'h0, 1'b1, 1'b0, 1'b1, IA, 1'b0, 1, 1'b0};
        tbl[2]  = '{1'b1, {IC, ID}, 1'b1, 1'b0, 1'b1, IB, 1'b1, 1, 1'b0};
        tbl[3]  = '{1'b0, 60'h0, 1'b1, 1'b0, 1'b1, IC, 1'b0, 1, 1'b0};
        tbl[4]  = '{1'b0, 60'h0, 1'b1, 1'b0, 1'b1, ID, 1'b1, 0, 1'b0};
        tbl[5]  = '{1'b0, 60'h0, 1'b1, 1'b0, 1'b0, Z, 1'b0, 0, 1'b0};
        tbl[6]  = '{1'b1, {30'h1111111, 30'h1222222}, 1'b0, 1'b0, 1'b0, Z, 1'b0, 1, 1'b0};
        tbl[7]  = '{1'b1, {30'h2111111, 30'h2222222}, 1'b0, 1'b0, 1'b1, 30'h1111111, 1'b0, 2, 1'b0};
        tbl[8]  = '{1'b1, {30'h3111111, 30'h3222222}, 1'b0, 1'b0, 1'b1, 30'h1111111, 1'b0, 3, 1'b0};
        tbl[9]  = '{1'b1, {30'h0111111, 30'h0222222}, 1'b0, 1'b0, 1'b1, 30'h1111111, 1'b0, 4, 1'b0};
        tbl[10] = '{1'b1, {30'h0333333, 30'h0444444}, 1'b0, 1'b0, 1'b1, 30'h1111111, 1'b0, 4, 1'b1};
        tbl[11] = '{1'b0, 60'h0, 1'b1, 1'b0, 1'b1, 30'h1222222, 1'b1, 3, 1'b1};

        repeat (2) @(negedge clock_i);
        chk_all_zero("reset");
        reset_i = 1'b1;

        for (int k = 0; k < 12; k++) begin
            cycle(tbl[k].bv, tbl[k].b, tbl[k].rdy, tbl[k].fl);
            chk_state($sformatf("vec%0d", k), tbl[k].ev, tbl[k].ei, tbl[k].es, tbl[k].ec, tbl[k].eo);
            if (k == 1) begin
                chk("vec1.imm_is_5", imm_o, 16'd5);
                chk("vec1.prim_is_1", prim_reg_o, 5'd1);
                chk("vec1.sec_is_0", sec_reg_o, 5'd0);
            end
            if (k == 3) begin
                chk("vec3.branch_is_1", branch_o, 1'b1);
                chk("vec3.sec_is_2", sec_reg_o, 5'd2);
                chk("vec3.imm_is_0", imm_o, 16'd0);
            end
        end

        // asynchronous reset between edges, with overflow set and the FIFO part full
        #2;
        reset_i = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clock_i);
        reset_i = 1'b1;

        // flush at count 3 together with a valid bundle
        cycle(1'b1, {30'h0A00001, 30'h0A00002}, 1'b0, 1'b0);
        cycle(1'b1, {30'h0B00001, 30'h0B00002}, 1'b0, 1'b0);
        cycle(1'b1, {30'h0C00001, 30'h0C00002}, 1'b0, 1'b0);
        chk_state("pre_flush", 1'b1, 30'h0A00001, 1'b0, 3, 1'b0);
        cycle(1'b1, {30'h0D00001, 30'h0D00002}, 1'b0, 1'b1);
        chk_state("flush", 1'b0, Z, 1'b0, 0, 1'b0);
        cycle(1'b0, 60'h0, 1'b1, 1'b0);
        chk_state("post_flush", 1'b0, Z, 1'b0, 0, 1'b0);
        cycle(1'b1, {30'h0E00001, 30'h0E00002}, 1'b1, 1'b0);
        chk_state("lat_e0", 1'b0, Z, 1'b0, 1, 1'b0);
        cycle(1'b0, 60'h0, 1'b1, 1'b0);
        chk_state("lat_e1", 1'b1, 30'h0E00001, 1'b0, 1, 1'b0);
        cycle(1'b0, 60'h0, 1'b1, 1'b0);
        chk_state("lat_e2", 1'b1, 30'h0E00002, 1'b1, 0, 1'b0);
        cycle(1'b0, 60'h0, 1'b1, 1'b0);

        // bundle with an all-zero slot 1
        cycle(1'b1, {ID, Z}, 1'b1, 1'b0);
        chk_state("nop_e0", 1'b0, Z, 1'b0, 1, 1'b0);
        cycle(1'b0, 60'h0, 1'b1, 1'b0);
`ifdef BUNDLE_NOP_SKIP_EN
        chk_state("nop_e1", 1'b1, ID, 1'b0, 0, 1'b0);
        cycle(1'b0, 60'h0, 1'b1, 1'b0);
        chk_state("nop_e2", 1'b0, Z, 1'b0, 0, 1'b0);
`else
        chk_state("nop_e1", 1'b1, ID, 1'b0, 1, 1'b0);
        cycle(1'b0, 60'h0, 1'b1, 1'b0);
        chk_state("nop_e2", 1'b1, Z, 1'b1, 0, 1'b0);
`endif

        // randomized run with non-zero slots against the queue model
        do_reset();
        q.delete();
        m_valid = 1'b0;
        m_instr = '0;
        m_slot = 1'b0;
        m_ovf = 1'b0;
        for (int n = 0; n < 600; n++) begin
            bv = $urandom_range(0, 99) < 60;
            rdy = $urandom_range(0, 99) < 65;
            fl = $urandom_range(0, 99) < 3;
            s0 = 30'($urandom);
            s1 = 30'($urandom);
            if (s0 == 0) s0 = 30'h1;
            if (s1 == 0) s1 = 30'h2;
            @(negedge clock_i);
            bundle_valid_i = bv;
            bundle_i = {s0, s1};
            ready_i = rdy;
            flush_i = fl;
            model_step(bv, {s0, s1}, rdy, fl);
            @(posedge clock_i);
            #1;
            chk_state($sformatf("rnd%0d", n), m_valid, m_instr, m_slot, (q.size() + 1) / 2, m_ovf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bundle_unpacker.md
# bundle_unpacker

Fetch-to-decode bridge. Accepts the 60-bit two-instruction bundles produced by the fetch stage, buffers them in a small FIFO, and issues one 30-bit instruction per cycle with pre-split fields over a valid/ready handshake. Sits between fetch and the decode/issue stage. Drives `stall_o` back to PC logic so the PC is held before the buffer can overflow.

## Interface
- `DEPTH`, 4: bundle FIFO entries; power of two, ≥ 2.
- `clock_i` input 1: single clock; all state on rising edge.
- `reset_i` input 1: reset, asynchronous, active-low; clears all state.
- `flush_i` input 1: synchronous flush from branch resolution.
- `bundle_i` input 60: bundle; [59:30] first instruction (slot 0), [29:0] second (slot 1).
- `bundle_valid_i` input 1: `bundle_i` valid this cycle; driven by fetch enable.
- `ready_i` input 1: decode accepts `instr_*` this cycle.
- `instr_valid_o` output 1: issued instruction valid.
- `instr_o` output 30: raw instruction.
- `format_o` output 1: instr[29]; 1 = reg-imm, 0 = reg-reg.
- `branch_o` output 1: instr[28].
- `opcode_o` output 7: instr[27:21].
- `prim_reg_o` output 5: instr[20:16].
- `sec_reg_o` output 5: instr[15:11]; zero when `format_o` = 1.
- `imm_o` output 16: instr[15:0]; zero when `format_o` = 0.
- `slot_o` output 1: source slot of the issued instruction.
- `stall_o` output 1: PC must hold.
- `overflow_o` output 1: sticky; a bundle was dropped.
- `count_o` output $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Push: `bundle_valid_i` and FIFO not full → write at tail. If full: bundle dropped, `overflow_o` set. `overflow_o` clears only on reset.
- Slot pointer `sp` (0/1) indexes the FIFO head. Output register loads when `!instr_valid_o || ready_i`.
- On load, with FIFO non-empty: issue head slot `sp`. If `sp` = 0, set `sp` = 1. If `sp` = 1, pop the head and set `sp` = 0.
- On load, with FIFO empty: `instr_valid_o` goes to 0.
- Field outputs are registered together with `instr_o`, so all fields change on the same edge.
- Push and pop on the same edge: count unchanged. Full and pop on the same edge: the push is accepted.
- `stall_o` = (count ≥ DEPTH−1), combinational from count. This leaves headroom for the one bundle already in flight from fetch.
- `flush_i` has priority over push and load:
  - Clears the FIFO pointers, count, `sp` and `instr_valid_o`.
  - Any bundle presented in the same cycle is discarded.
  - `overflow_o` is unchanged.
- Reset mid-operation: all state cleared immediately (asynchronous). No partial issue.

## Timing
- Reset values: all outputs 0. `stall_o` = 0 and `count_o` = 0, since the FIFO is empty.
- Latency, empty FIFO: bundle captured at edge E0; slot 0 visible on `instr_*` after E1; slot 1 after E2, provided `ready_i` is held high.
- Throughput: one instruction per cycle, i.e. one bundle per two cycles, with `ready_i` continuously high.
- Hold rule: `instr_*` stay stable while `instr_valid_o && !ready_i`.
- Flush: `instr_valid_o` = 0 in the cycle after the flush edge. The first post-flush bundle follows the 2-edge latency.

## Configuration
- `BUNDLE_NOP_SKIP_EN` defined: an all-zero 30-bit slot is never issued.
  - At `sp` = 0 with slot 0 zero and slot 1 non-zero: issue slot 1 and pop.
  - Both slots zero: pop without issuing. A load occurring then leaves `instr_valid_o` = 0 unless a later entry supplies an instruction; at most one bundle is popped per edge.
  - After issuing slot 0, if slot 1 is zero: pop on that same edge.
- Not defined: every slot is issued, including zero slots.

## Structure
- Shared package `pa_isa_pkg`:
  - `INSTR_W` = 30, `BUNDLE_W` = 60.
  - Field bit positions: FORMAT, BRANCH, OPCODE, PRIM, SEC, IMM.
  - `NOP_INSTR` = 30'b0.
  - Packed struct `instr_fields_t`. Fetch and decode reuse the package.
- One sub-module, `bundle_fifo`: a DEPTH-entry 60-bit circular buffer exposing push/pop/full/empty/count. Slot sequencing and field split stay in `bundle_unpacker`.

## Test plan
- Reset, then push bundle {slot 0 = reg-imm, opcode 0001010, prim 00001, imm 5; slot 1 = prim 00010, imm 10} with `ready_i` = 1:
  - After E1: `imm_o` = 5, `prim_reg_o` = 1, `slot_o` = 0, `format_o` = 1, `sec_reg_o` = 0.
  - After E2: `imm_o` = 10, `slot_o` = 1.
- Reg-reg slot with branch = 1, opcode 0000110, prim 00011, sec 00010 → `branch_o` = 1, `sec_reg_o` = 2, `imm_o` = 0.
- `ready_i` = 0 with 4 bundles pushed (DEPTH = 4):
  - `stall_o` rises when count = 3; the 4th push is accepted; a 5th push sets `overflow_o` = 1 with count staying at 4.
  - Outputs stay frozen.
- `flush_i` asserted at count = 3 together with a valid bundle → count = 0 and `instr_valid_o` = 0 next cycle; the bundle is not issued; `overflow_o` is unchanged.
- `reset_i` asserted low mid-stream, asynchronously between edges → all outputs read 0 before the next clock edge.
- Bundle with slot 1 = 0:
  - With `BUNDLE_NOP_SKIP_EN`: one instruction issued and count drops after one edge.
  - Without it: two issues, the second with `instr_o` = 0.
